data_mem_stage: RTL
===================

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Parameters
REQ-001 SHALL provide ADDR_W, default 14, meaning word-address bits; capacity is 4*2^ADDR_W bytes, held as four byte lanes.
REQ-002 SHALL provide LATENCY, default 1, legal range 0..7, meaning extra wait cycles a load spends before its result is presented.

Interface
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  clock, all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ir_in, a_in, b_in, pc_in  in  32 each  instruction, effective address, store data, PC.
REQ-007 v_in  in  1  upstream valid; r_out  out  1  ready to upstream.
REQ-008 v_out  out  1  downstream valid; r_in  in  1  downstream ready.
REQ-009 stall  in  1  flush: drops any pending or held result.
REQ-010 ir_out, a_out, pc_out, rd_out  out  32 each  forwarded IR/A/PC and load data.
REQ-011 err_out  out  1  access fault flag for the presented result.

Function
REQ-012 A memory op SHALL have opcode 0000011 (load) or 0100011 (store); every other opcode is a pass-through op.
REQ-013 FSM states: IDLE, WAIT, HOLD.
REQ-014 r_out SHALL be 1 only in IDLE; a transfer occurs when v_in & r_out.
REQ-015 IDLE, transfer of a load with LATENCY>0: go to WAIT and load the counter with LATENCY.
REQ-016 IDLE, transfer of a store, a pass-through op, or a load with LATENCY=0: go to HOLD on the next edge.
REQ-017 WAIT: decrement the counter each cycle; on reaching 0, read memory, go to HOLD.
REQ-018 HOLD: v_out=1 with all outputs stable; on r_in, return to IDLE.
REQ-019 Total load latency SHALL be LATENCY+1 cycles from transfer to v_out.
REQ-020 Throughput SHALL be one op per 2 cycles minimum; no back-to-back acceptance while in HOLD.
REQ-021 ir_out/a_out/pc_out SHALL be captured at the transfer edge.
REQ-022 Loads, by funct3: 0 LB sign-extend, 4 LBU zero-extend, 1 LH sign-extend, 5 LHU zero-extend, 2 LW.
REQ-023 Stores, by funct3: 0 SB, 1 SH, 2 SW; byte lanes are written at the transfer edge using a 4-bit byte enable decoded from a_in[1:0].
REQ-024 Fault conditions: LH/LHU/SH with a_in[0]=1; LW/SW with a_in[1:0]!=0; a_in[31:ADDR_W+2]!=0 (no wrap); illegal funct3 (3, 6, 7 for loads; 3..7 for stores).
REQ-025 On a fault: err_out=1, rd_out=0, no memory write; the op is still presented in HOLD.
REQ-026 For stores and pass-through ops, rd_out=0 and err_out=0 unless a fault applies.
REQ-027 stall=1 SHALL force the FSM to IDLE and v_out=0 on the next edge, aborting a WAIT; a store already written stays written.
REQ-028 stall SHALL take priority over r_in and over a simultaneous transfer; no write occurs on a stalled cycle.

Reset
REQ-029 When rst_n=0, asynchronously: state=IDLE, counter=0, v_out=0, err_out=0, and ir_out, a_out, pc_out, rd_out = 0.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 Reset asserted mid-WAIT SHALL discard the load.
REQ-032 r_out SHALL be 1 on the first edge after rst_n deasserts.

Verification
REQ-033 SW a=0x10 b=0x8081_8283, then LW a=0x10, LATENCY=1 -> v_out 2 cycles after transfer, rd_out=0x8081_8283, err_out=0.
REQ-034 After REQ-033: LB a=0x10 -> 0xFFFF_FF83; LBU a=0x10 -> 0x0000_0083; LH a=0x12 -> 0xFFFF_8081; LHU a=0x12 -> 0x0000_8081.
REQ-035 SW a=0x13 -> err_out=1, rd_out=0, and a following LW a=0x10 still returns the prior value; LW a=4*2^ADDR_W -> err_out=1.
REQ-036 r_in held 0 for 5 cycles in HOLD -> outputs stable, r_out=0; then r_in=1 -> IDLE and next op accepted on the following cycle.
REQ-037 stall=1 during WAIT of LW -> v_out stays 0, r_out=1 next cycle; rst_n pulsed low mid-WAIT -> all outputs 0 immediately, memory intact.

Source files
------------

// File: rtl/data_mem_stage.sv
// Data-memory pipeline stage: byte-lane memory with load/store decode,
// programmable load latency and a valid/ready handshake on both sides.
module data_mem_stage #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] pc_in,
    input  logic        v_in,
    output logic        r_out,
    output logic        v_out,
    input  logic        r_in,
    input  logic        stall,
    output logic [31:0] ir_out,
    output logic [31:0] a_out,
    output logic [31:0] pc_out,
    output logic [31:0] rd_out,
    output logic        err_out
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [2:0]  LAT3     = 3'(LATENCY);

    logic [3:0][7:0] mem [DEPTH];

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] ir_q, ir_d, a_q, a_d, pc_q, pc_d, rd_q, rd_d;
    logic        err_q, err_d;

    logic              in_load, in_store, in_oor, in_fault, we;
    logic [2:0]        in_f3;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] widx_in, widx_q;

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    load_ext = {{24{b[7]}}, b};
            3'd4:    load_ext = {24'b0, b};
            3'd1:    load_ext = {{16{h[15]}}, h};
            3'd5:    load_ext = {16'b0, h};
            default: load_ext = w;
        endcase
    endfunction

    assign in_load  = (ir_in[6:0] == OP_LOAD);
    assign in_store = (ir_in[6:0] == OP_STORE);
    assign in_f3    = ir_in[14:12];
    assign in_oor   = ((a_in >> (ADDR_W + 2)) != '0);
    assign widx_in  = a_in[ADDR_W+1:2];
    assign widx_q   = a_q[ADDR_W+1:2];

    always_comb begin
        in_fault = 1'b0;
        if (in_load) begin
            case (in_f3)
                3'd0, 3'd4: in_fault = in_oor;
                3'd1, 3'd5: in_fault = in_oor | a_in[0];
                3'd2:       in_fault = in_oor | (a_in[1:0] != 2'b00);
                default:    in_fault = 1'b1;
            endcase
        end else if (in_store) begin
            case (in_f3)
                3'd0:    in_fault = in_oor;
                3'd1:    in_fault = in_oor | a_in[0];
                3'd2:    in_fault = in_oor | (a_in[1:0] != 2'b00);
                default: in_fault = 1'b1;
            endcase
        end
    end

    always_comb begin
        be    = 4'b1111;
        wdata = b_in;
        case (in_f3)
            3'd0: begin
                be    = 4'b0001 << a_in[1:0];
                wdata = {4{b_in[7:0]}};
            end
            3'd1: begin
                be    = a_in[1] ? 4'b1100 : 4'b0011;
                wdata = {2{b_in[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        a_d     = a_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        err_d   = err_q;
        we      = 1'b0;
        // stall outranks every other action, including a transfer in IDLE
        if (stall) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (v_in) begin
                        ir_d  = ir_in;
                        a_d   = a_in;
                        pc_d  = pc_in;
                        err_d = in_fault;
                        rd_d  = '0;
                        we    = in_store & ~in_fault;
                        if (in_load && LATENCY != 0) begin
                            state_d = WAIT;
                            cnt_d   = LAT3;
                        end else begin
                            state_d = HOLD;
                            if (in_load && !in_fault)
                                rd_d = load_ext(mem[widx_in], a_in[1:0], in_f3);
                        end
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = HOLD;
                        rd_d    = err_q ? '0 : load_ext(mem[widx_q], a_q[1:0], ir_q[14:12]);
                    end
                end
                HOLD: begin
                    if (r_in)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // Memory array has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i])
                    mem[widx_in][i] <= wdata[i*8 +: 8];
            end
        end
    end

    assign r_out   = (state_q == IDLE);
    assign v_out   = (state_q == HOLD);
    assign ir_out  = ir_q;
    assign a_out   = a_q;
    assign pc_out  = pc_q;
    assign rd_out  = rd_q;
    assign err_out = err_q;

endmodule
